// File: rtl/kill_event_arbiter.sv
// Queues per-source hit reports and grants at most one kill per frame in round-robin order.
// A shadow score stops all grants at MAX_SCORE so the BCD kill display never wraps.
module kill_event_arbiter #(
  parameter int N_REQ     = 4,
  parameter int SRC_W     = 2,
  parameter int CNT_W     = 3,
  parameter int MAX_SCORE = 9999
) (
  input  logic             frame_clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] hit_req,
  input  logic             game_active,
  output logic             kill,
  output logic [SRC_W-1:0] kill_src,
  output logic [13:0]      score,
  output logic             pending_any,
  output logic [N_REQ-1:0] overflow,
  output logic             score_sat
);

  localparam int                N_SLOT     = 1 << SRC_W;
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [13:0]       SCORE_LAST = 14'(MAX_SCORE - 1);
  localparam logic [SRC_W-1:0]  LAST_SRC   = SRC_W'(N_REQ - 1);
  localparam logic [SRC_W:0]    N_REQ_EXT  = (SRC_W + 1)'(N_REQ);

  typedef enum logic [1:0] {IDLE, RUN, SAT} state_t;

  state_t             state_reg, state_next;
  logic [SRC_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [13:0]        score_reg, score_next;
  logic               kill_reg;
  logic [SRC_W-1:0]   kill_src_reg, kill_src_next;
  logic [N_REQ-1:0]   overflow_reg, overflow_next;
  logic               pending_any_reg;
  logic [N_REQ-1:0]   pending_nz_next;
  logic [N_SLOT-1:0]  nonzero;
  logic               running;
  logic               grant_valid;
  logic [SRC_W-1:0]   grant_idx;

  assign running = (state_reg == RUN) && game_active;

  // Per-source pending counters; padded slots above N_REQ never request.
  generate
    for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_src
      if (gi < N_REQ) begin : g_live
        logic [CNT_W-1:0] cnt_reg, cnt_next;
        logic             ovf_next;
        logic             gnt;

        assign gnt = grant_valid && (grant_idx == SRC_W'(gi));

        always_comb begin
          cnt_next = '0;
          ovf_next = overflow_reg[gi];
          if (running) begin
            if (hit_req[gi] && !gnt) begin
              if (cnt_reg == CNT_MAX) begin
                cnt_next = cnt_reg;
                ovf_next = 1'b1;
              end else begin
                cnt_next = cnt_reg + CNT_W'(1);
              end
            end else if (!hit_req[gi] && gnt) begin
              cnt_next = cnt_reg - CNT_W'(1);
            end else begin
              cnt_next = cnt_reg;
            end
            if (state_next != RUN) cnt_next = '0;
          end
        end

        always_ff @(posedge frame_clk) begin
          if (reset) cnt_reg <= '0;
          else       cnt_reg <= cnt_next;
        end

        assign nonzero[gi]         = |cnt_reg;
        assign pending_nz_next[gi] = |cnt_next;
        assign overflow_next[gi]   = ovf_next;
      end else begin : g_pad
        assign nonzero[gi] = 1'b0;
      end
    end
  endgenerate

  // Walk from the far end back toward rr_ptr so the nearest requester wins.
  always_comb begin
    logic [SRC_W:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = {1'b0, rr_ptr_reg} + (SRC_W + 1)'(off);
      if (cand >= N_REQ_EXT) cand = cand - N_REQ_EXT;
      if (nonzero[cand[SRC_W-1:0]]) begin
        grant_valid = running;
        grant_idx   = cand[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    score_next    = score_reg;
    rr_ptr_next   = rr_ptr_reg;
    kill_src_next = kill_src_reg;
    case (state_reg)
      IDLE: if (game_active) state_next = RUN;
      RUN: begin
        if (!game_active) begin
          state_next = IDLE;
        end else if (grant_valid) begin
          score_next    = score_reg + 14'd1;
          kill_src_next = grant_idx;
          rr_ptr_next   = (grant_idx == LAST_SRC) ? '0 : grant_idx + SRC_W'(1);
          if (score_reg == SCORE_LAST) state_next = SAT;
        end
      end
      SAT: state_next = SAT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      score_reg       <= '0;
      kill_reg        <= 1'b0;
      kill_src_reg    <= '0;
      overflow_reg    <= '0;
      pending_any_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      score_reg       <= score_next;
      kill_reg        <= grant_valid;
      kill_src_reg    <= kill_src_next;
      overflow_reg    <= overflow_next;
      pending_any_reg <= |pending_nz_next;
    end
  end

  assign kill        = kill_reg;
  assign kill_src    = kill_src_reg;
  assign score       = score_reg;
  assign pending_any = pending_any_reg;
  assign overflow    = overflow_reg;
  assign score_sat   = (state_reg == SAT);

endmodule

// File: tb/tb_kill_event_arbiter.sv
// Directed bench for kill_event_arbiter: default instance plus a MAX_SCORE=5 instance.
module tb_kill_event_arbiter;

  logic        frame_clk;
  logic        reset;
  logic        reset_b;
  logic [3:0]  hit_req;
  logic        game_active;

  logic        kill, pending_any, score_sat;
  logic [1:0]  kill_src;
  logic [13:0] score;
  logic [3:0]  overflow;

  logic        b_kill, b_pending_any, b_score_sat;
  logic [1:0]  b_kill_src;
  logic [13:0] b_score;
  logic [3:0]  b_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  kill_event_arbiter dut (
    .frame_clk(frame_clk), .reset(reset), .hit_req(hit_req), .game_active(game_active),
    .kill(kill), .kill_src(kill_src), .score(score), .pending_any(pending_any),
    .overflow(overflow), .score_sat(score_sat)
  );

  kill_event_arbiter #(.MAX_SCORE(5)) dut_sat (
    .frame_clk(frame_clk), .reset(reset_b), .hit_req(hit_req), .game_active(game_active),
    .kill(b_kill), .kill_src(b_kill_src), .score(b_score), .pending_any(b_pending_any),
    .overflow(b_overflow), .score_sat(b_score_sat)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  // Reset the main instance and leave it in RUN with nothing pending.
  task automatic restart();
    reset = 1'b1; hit_req = 4'b0000; game_active = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; game_active = 1'b0; hit_req = 4'b0000;
    step(); step();
    n_checks++; if (kill !== 1'b0) begin n_fail++; $display("FAIL reset_kill: got %0b expected 0", kill); end
    n_checks++; if (kill_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d expected 0", kill_src); end
    n_checks++; if (score !== 14'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
    n_checks++; if (pending_any !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %0b expected 0", pending_any); end
    n_checks++; if (overflow !== 4'b0000) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0000", overflow); end
    n_checks++; if (score_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %0b expected 0", score_sat); end
    $display("test_reset done");
  endtask

  task automatic test_single_hit();
    restart();
    hit_req = 4'b0001;
    step();
    n_checks++; if (kill !== 1'b0) begin n_fail++; $display("FAIL single_early: got kill=%0b expected 0", kill); end
    n_checks++; if (pending_any !== 1'b1) begin n_fail++; $display("FAIL single_pend: got %0b expected 1", pending_any); end
    hit_req = 4'b0000;
    step();
    n_checks++; if (kill !== 1'b1 || kill_src !== 2'd0) begin n_fail++; $display("FAIL single_grant: got kill=%0b src=%0d expected kill=1 src=0", kill, kill_src); end
    n_checks++; if (score !== 14'd1) begin n_fail++; $display("FAIL single_score: got %0d expected 1", score); end
    n_checks++; if (pending_any !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %0b expected 0", pending_any); end
    step();
    n_checks++; if (kill !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got kill=%0b expected 0", kill); end
    $display("test_single_hit done");
  endtask

  task automatic test_back_to_back();
    restart();
    hit_req = 4'b1111;
    step();
    n_checks++; if (kill !== 1'b0) begin n_fail++; $display("FAIL b2b_same_edge: got kill=%0b expected 0", kill); end
    hit_req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (kill !== 1'b1 || kill_src !== 2'(i)) begin
        n_fail++; $display("FAIL b2b_grant[%0d]: got kill=%0b src=%0d expected kill=1 src=%0d", i, kill, kill_src, i);
      end
    end
    n_checks++; if (score !== 14'd4) begin n_fail++; $display("FAIL b2b_score: got %0d expected 4", score); end
    step();
    n_checks++; if (kill !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got kill=%0b expected 0", kill); end
    hit_req = 4'b0011;
    step();
    hit_req = 4'b0000;
    step();
    n_checks++; if (kill !== 1'b1 || kill_src !== 2'd0) begin n_fail++; $display("FAIL b2b_second0: got kill=%0b src=%0d expected kill=1 src=0", kill, kill_src); end
    step();
    n_checks++; if (kill !== 1'b1 || kill_src !== 2'd1) begin n_fail++; $display("FAIL b2b_second1: got kill=%0b src=%0d expected kill=1 src=1", kill, kill_src); end
    n_checks++; if (score !== 14'd6) begin n_fail++; $display("FAIL b2b_score2: got %0d expected 6", score); end
    step();
    n_checks++; if (kill !== 1'b0 || pending_any !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got kill=%0b pend=%0b expected 0 0", kill, pending_any); end
    $display("test_back_to_back done");
  endtask

  task automatic test_hold_saturate();
    logic [1:0] exp_src;
    logic [3:0] exp_ovf;
    restart();
    hit_req = 4'b0100;
    step();
    n_checks++; if (kill !== 1'b0) begin n_fail++; $display("FAIL hold_first: got kill=%0b expected 0", kill); end
    for (int e = 2; e <= 10; e++) begin
      step();
      n_checks++;
      if (kill !== 1'b1 || kill_src !== 2'd2 || overflow !== 4'b0000) begin
        n_fail++; $display("FAIL hold_edge[%0d]: got kill=%0b src=%0d ovf=%b expected 1 2 0000", e, kill, kill_src, overflow);
      end
    end
    n_checks++; if (score !== 14'd9) begin n_fail++; $display("FAIL hold_score: got %0d expected 9", score); end
    hit_req = 4'b0000;
    step();
    n_checks++; if (kill !== 1'b1 || kill_src !== 2'd2) begin n_fail++; $display("FAIL hold_last: got kill=%0b src=%0d expected 1 2", kill, kill_src); end
    step();
    n_checks++; if (kill !== 1'b0 || pending_any !== 1'b0) begin n_fail++; $display("FAIL hold_drain: got kill=%0b pend=%0b expected 0 0", kill, pending_any); end

    hit_req = 4'b0101;
    step();
    n_checks++; if (kill !== 1'b0) begin n_fail++; $display("FAIL alt_first: got kill=%0b expected 0", kill); end
    for (int e = 2; e <= 15; e++) begin
      step();
      exp_src = (e % 2 == 0) ? 2'd0 : 2'd2;
      exp_ovf = (e < 14) ? 4'b0000 : ((e == 14) ? 4'b0100 : 4'b0101);
      n_checks++;
      if (kill !== 1'b1 || kill_src !== exp_src) begin
        n_fail++; $display("FAIL alt_grant[%0d]: got kill=%0b src=%0d expected 1 %0d", e, kill, kill_src, exp_src);
      end
      n_checks++;
      if (overflow !== exp_ovf) begin
        n_fail++; $display("FAIL alt_ovf[%0d]: got %b expected %b", e, overflow, exp_ovf);
      end
    end
    hit_req = 4'b0000;
    for (int j = 0; j < 14; j++) begin
      step();
      exp_src = (j % 2 == 0) ? 2'd0 : 2'd2;
      n_checks++;
      if (kill !== 1'b1 || kill_src !== exp_src) begin
        n_fail++; $display("FAIL alt_drain[%0d]: got kill=%0b src=%0d expected 1 %0d", j, kill, kill_src, exp_src);
      end
    end
    n_checks++; if (pending_any !== 1'b0) begin n_fail++; $display("FAIL alt_empty: got %0b expected 0", pending_any); end
    n_checks++; if (score !== 14'd38) begin n_fail++; $display("FAIL alt_score: got %0d expected 38", score); end
    step();
    n_checks++; if (kill !== 1'b0 || overflow !== 4'b0101) begin n_fail++; $display("FAIL alt_end: got kill=%0b ovf=%b expected 0 0101", kill, overflow); end
    $display("test_hold_saturate done");
  endtask

  task automatic test_game_inactive();
    restart();
    hit_req = 4'b0111;
    step();
    hit_req = 4'b0000;
    step();
    n_checks++; if (kill !== 1'b1 || kill_src !== 2'd0 || score !== 14'd1) begin n_fail++; $display("FAIL inact_grant: got kill=%0b src=%0d score=%0d expected 1 0 1", kill, kill_src, score); end
    game_active = 1'b0;
    step();
    n_checks++; if (kill !== 1'b0 || pending_any !== 1'b0) begin n_fail++; $display("FAIL inact_flush: got kill=%0b pend=%0b expected 0 0", kill, pending_any); end
    n_checks++; if (score !== 14'd1) begin n_fail++; $display("FAIL inact_score: got %0d expected 1", score); end
    step();
    game_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (kill !== 1'b0) begin n_fail++; $display("FAIL inact_stale[%0d]: got kill=%0b expected 0", i, kill); end
    end
    n_checks++; if (score !== 14'd1 || pending_any !== 1'b0) begin n_fail++; $display("FAIL inact_end: got score=%0d pend=%0b expected 1 0", score, pending_any); end
    $display("test_game_inactive done");
  endtask

  task automatic test_score_sat();
    logic [1:0] exp_src [4];
    exp_src[0] = 2'd1; exp_src[1] = 2'd2; exp_src[2] = 2'd3; exp_src[3] = 2'd0;
    reset = 1'b1; reset_b = 1'b1; game_active = 1'b1; hit_req = 4'b0000;
    step();
    reset_b = 1'b0;
    step();
    hit_req = 4'b1111;
    step();
    n_checks++; if (b_kill !== 1'b0) begin n_fail++; $display("FAIL sat_first: got kill=%0b expected 0", b_kill); end
    hit_req = 4'b0111;
    step();
    n_checks++; if (b_kill !== 1'b1 || b_kill_src !== 2'd0 || b_score !== 14'd1) begin n_fail++; $display("FAIL sat_g0: got kill=%0b src=%0d score=%0d expected 1 0 1", b_kill, b_kill_src, b_score); end
    hit_req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (b_kill !== 1'b1 || b_kill_src !== exp_src[i]) begin
        n_fail++; $display("FAIL sat_grant[%0d]: got kill=%0b src=%0d expected 1 %0d", i, b_kill, b_kill_src, exp_src[i]);
      end
    end
    n_checks++; if (b_score !== 14'd5 || b_score_sat !== 1'b1) begin n_fail++; $display("FAIL sat_reach: got score=%0d sat=%0b expected 5 1", b_score, b_score_sat); end
    n_checks++; if (b_pending_any !== 1'b0) begin n_fail++; $display("FAIL sat_flush: got %0b expected 0", b_pending_any); end
    hit_req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      game_active = (i % 2 == 0) ? 1'b0 : 1'b1;
      step();
      n_checks++;
      if (b_kill !== 1'b0 || b_score !== 14'd5 || b_score_sat !== 1'b1) begin
        n_fail++; $display("FAIL sat_hold[%0d]: got kill=%0b score=%0d sat=%0b expected 0 5 1", i, b_kill, b_score, b_score_sat);
      end
    end
    hit_req = 4'b0000;
    reset_b = 1'b1;
    step();
    n_checks++; if (b_score !== 14'd0 || b_score_sat !== 1'b0 || b_kill !== 1'b0) begin n_fail++; $display("FAIL sat_reset: got score=%0d sat=%0b kill=%0b expected 0 0 0", b_score, b_score_sat, b_kill); end
    reset_b = 1'b0; game_active = 1'b0;
    step();
    n_checks++; if (b_score_sat !== 1'b0 || b_kill !== 1'b0) begin n_fail++; $display("FAIL sat_idle: got sat=%0b kill=%0b expected 0 0", b_score_sat, b_kill); end
    reset_b = 1'b1;
    $display("test_score_sat done");
  endtask

  task automatic test_reset_midrun();
    restart();
    hit_req = 4'b0001;
    step();
    hit_req = 4'b0011;
    step();
    n_checks++; if (kill !== 1'b1 || kill_src !== 2'd0) begin n_fail++; $display("FAIL mid_g0: got kill=%0b src=%0d expected 1 0", kill, kill_src); end
    step();
    n_checks++; if (kill !== 1'b1 || kill_src !== 2'd1) begin n_fail++; $display("FAIL mid_g1: got kill=%0b src=%0d expected 1 1", kill, kill_src); end
    reset = 1'b1; hit_req = 4'b1111;
    step();
    n_checks++; if (kill !== 1'b0 || pending_any !== 1'b0 || score !== 14'd0) begin n_fail++; $display("FAIL mid_reset: got kill=%0b pend=%0b score=%0d expected 0 0 0", kill, pending_any, score); end
    reset = 1'b0; hit_req = 4'b0000; game_active = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (kill !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: got kill=%0b expected 0", i, kill); end
    end
    n_checks++; if (score !== 14'd0 || pending_any !== 1'b0) begin n_fail++; $display("FAIL mid_end: got score=%0d pend=%0b expected 0 0", score, pending_any); end
    $display("test_reset_midrun done");
  endtask

  initial begin
    reset = 1'b1; reset_b = 1'b1; hit_req = 4'b0000; game_active = 1'b0;
    test_reset();
    test_single_hit();
    test_back_to_back();
    test_hold_saturate();
    test_game_inactive();
    test_score_sat();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
